tx_data_fifo: RTL and testbench

- Single-clock, store-and-forward transmit data FIFO in the 156.25 MHz core domain.
- Buffers 64-bit frame words plus 8-bit per-word status from the packet interface until the TX MAC dequeues them.
- Counts complete frames so the TX MAC only starts a frame that is fully buffered; no underrun is possible mid-frame.
- Show-ahead (early-read) output: the head entry is always presented when the FIFO is non-empty.

---
 rtl/tx_data_fifo_pkg.sv | 9 +
 rtl/tx_fifo_ctrl.sv | 68 ++++++
 rtl/tx_data_fifo.sv | 63 ++++++
 tb/tb_tx_data_fifo.sv | 139 +++++++++++++
 4 files changed

// File: rtl/tx_data_fifo_pkg.sv
// tx_data_fifo_pkg: shared depth and word-status bit positions for the TX data FIFO
package tx_data_fifo_pkg;
    localparam int TX_DATA_FIFO_AWIDTH = 8;
    localparam int STATUS_SOP = 0;
    localparam int STATUS_EOP = 1;
    localparam int STATUS_ERR = 2;
    localparam int STATUS_BCNT_LSB = 3;
    localparam int STATUS_BCNT_MSB = 5;
endpackage

// File: rtl/tx_fifo_ctrl.sv
// tx_fifo_ctrl: pointers, level flags, complete-frame counter and sticky errors for tx_data_fifo
// Ports: clk_156m25/reset_156m25 clock and sync reset; wen/ren raw strobes; weop/reop EOP bit of
// the incoming and head words; wr_ok accepted write; waddr/raddr storage addresses; registered flags.
module tx_fifo_ctrl
    import tx_data_fifo_pkg::*;
#(
    parameter int AWIDTH = TX_DATA_FIFO_AWIDTH,
    parameter int ALMOST_FULL_THRESH = 16,
    parameter int ALMOST_EMPTY_THRESH = 4
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    input  logic              wen,
    input  logic              ren,
    input  logic              weop,
    input  logic              reop,
    output logic              wr_ok,
    output logic [AWIDTH-1:0] waddr,
    output logic [AWIDTH-1:0] raddr,
    output logic              wfull,
    output logic              walmost_full,
    output logic              rempty,
    output logic              ralmost_empty,
    output logic              ravail,
    output logic              overflow,
    output logic              underflow
);
    localparam int PW = AWIDTH + 1;
    localparam logic [AWIDTH:0] DEPTH = PW'(1 << AWIDTH);
    logic [AWIDTH:0] wptr, rptr, fcnt, wptr_nxt, rptr_nxt, occ_nxt, fcnt_nxt;
    logic rd_ok;
    assign wr_ok = wen & ~wfull;
    assign rd_ok = ren & ~rempty;
    assign waddr = wptr[AWIDTH-1:0];
    assign raddr = rptr[AWIDTH-1:0];
    // Flags are registered from the post-event state so they are exact one cycle after each event.
    always_comb begin
        wptr_nxt = wptr + PW'(wr_ok);
        rptr_nxt = rptr + PW'(rd_ok);
        occ_nxt  = wptr_nxt - rptr_nxt;
        fcnt_nxt = fcnt + PW'(wr_ok & weop) - PW'(rd_ok & reop);
    end
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            wptr          <= '0;
            rptr          <= '0;
            fcnt          <= '0;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            ravail        <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            wptr          <= wptr_nxt;
            rptr          <= rptr_nxt;
            fcnt          <= fcnt_nxt;
            wfull         <= occ_nxt == DEPTH;
            walmost_full  <= (DEPTH - occ_nxt) <= PW'(ALMOST_FULL_THRESH);
            rempty        <= occ_nxt == '0;
            ralmost_empty <= occ_nxt <= PW'(ALMOST_EMPTY_THRESH);
            ravail        <= fcnt_nxt != '0;
            overflow      <= overflow | (wen & wfull);
            underflow     <= underflow | (ren & rempty);
        end
    end
endmodule

// File: rtl/tx_data_fifo.sv
// tx_data_fifo: store-and-forward show-ahead TX data FIFO of 64-bit words with 8-bit status
// Ports: clk_156m25/reset_156m25 clock and sync reset; txdfifo_w* write side (data, status, strobe,
// full flags); txdfifo_r* read side (pop strobe, head data/status, empty flags, frame available);
// txdfifo_overflow/underflow sticky error flags.
module tx_data_fifo
    import tx_data_fifo_pkg::*;
#(
    parameter int AWIDTH = TX_DATA_FIFO_AWIDTH,
    parameter int ALMOST_FULL_THRESH = 16,
    parameter int ALMOST_EMPTY_THRESH = 4
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25,
    input  logic [63:0] txdfifo_wdata,
    input  logic [7:0]  txdfifo_wstatus,
    input  logic        txdfifo_wen,
    output logic        txdfifo_wfull,
    output logic        txdfifo_walmost_full,
    input  logic        txdfifo_ren,
    output logic [63:0] txdfifo_rdata,
    output logic [7:0]  txdfifo_rstatus,
    output logic        txdfifo_rempty,
    output logic        txdfifo_ralmost_empty,
    output logic        txdfifo_ravail,
    output logic        txdfifo_overflow,
    output logic        txdfifo_underflow
);
    localparam int DEPTH = 1 << AWIDTH;
    logic [71:0] mem [DEPTH];
    logic [71:0] head;
    logic [AWIDTH-1:0] waddr, raddr;
    logic wr_ok;
    tx_fifo_ctrl #(
        .AWIDTH(AWIDTH),
        .ALMOST_FULL_THRESH(ALMOST_FULL_THRESH),
        .ALMOST_EMPTY_THRESH(ALMOST_EMPTY_THRESH)
    ) u_ctrl (
        .clk_156m25(clk_156m25),
        .reset_156m25(reset_156m25),
        .wen(txdfifo_wen),
        .ren(txdfifo_ren),
        .weop(txdfifo_wstatus[STATUS_EOP]),
        .reop(txdfifo_rstatus[STATUS_EOP]),
        .wr_ok(wr_ok),
        .waddr(waddr),
        .raddr(raddr),
        .wfull(txdfifo_wfull),
        .walmost_full(txdfifo_walmost_full),
        .rempty(txdfifo_rempty),
        .ralmost_empty(txdfifo_ralmost_empty),
        .ravail(txdfifo_ravail),
        .overflow(txdfifo_overflow),
        .underflow(txdfifo_underflow)
    );
    // Storage is not reset; contents are only meaningful behind valid pointers.
    always_ff @(posedge clk_156m25) begin
        if (wr_ok) mem[waddr] <= {txdfifo_wstatus, txdfifo_wdata};
    end
    // Combinational read at the read pointer gives zero-latency show-ahead.
    assign head = mem[raddr];
    assign txdfifo_rdata = head[63:0];
    assign txdfifo_rstatus = head[71:64];
endmodule

// File: tb/tb_tx_data_fifo.sv
// tb_tx_data_fifo: directed self-checking bench for tx_data_fifo
module tb_tx_data_fifo;
    logic clk = 1'b0, rst = 1'b1;
    logic [63:0] wdata = '0;
    logic [7:0] wstatus = '0;
    logic wen = 1'b0, ren = 1'b0;
    logic wfull, walmost_full, rempty, ralmost_empty, ravail, overflow, underflow;
    logic [63:0] rdata;
    logic [7:0] rstatus;
    int tests = 0, fails = 0;
    tx_data_fifo dut (
        .clk_156m25(clk),
        .reset_156m25(rst),
        .txdfifo_wdata(wdata),
        .txdfifo_wstatus(wstatus),
        .txdfifo_wen(wen),
        .txdfifo_wfull(wfull),
        .txdfifo_walmost_full(walmost_full),
        .txdfifo_ren(ren),
        .txdfifo_rdata(rdata),
        .txdfifo_rstatus(rstatus),
        .txdfifo_rempty(rempty),
        .txdfifo_ralmost_empty(ralmost_empty),
        .txdfifo_ravail(ravail),
        .txdfifo_overflow(overflow),
        .txdfifo_underflow(underflow)
    );
    always #3.2 clk = ~clk;
    // flags order: rempty ralmost_empty wfull walmost_full ravail overflow underflow
    wire [6:0] flags = {rempty, ralmost_empty, wfull, walmost_full, ravail, overflow, underflow};
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic wr(input logic [63:0] d, input logic [7:0] s);
        wdata = d;
        wstatus = s;
        wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask
    task automatic pop_chk(input string tag, input logic [63:0] d, input logic [7:0] s);
        chk(tag, {rstatus, rdata}, {s, d});
        ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask
    initial begin
        tick();
        tick();
        chk("reset_flags", 72'(flags), 72'(7'b1100000));
        rst = 1'b0;
        tick();
        // single three-word frame
        wr(64'h1111_1111_1111_1111, 8'h01);
        chk("first_word_visible", {71'(rempty), rdata}, {71'(0), 64'h1111_1111_1111_1111});
        wr(64'h2222_2222_2222_2222, 8'h00);
        chk("ravail_before_eop", 72'(ravail), 72'(0));
        wr(64'h3333_3333_3333_3333, 8'h02);
        chk("ravail_after_eop", 72'(ravail), 72'(1));
        pop_chk("frame_w0", 64'h1111_1111_1111_1111, 8'h01);
        pop_chk("frame_w1", 64'h2222_2222_2222_2222, 8'h00);
        pop_chk("frame_w2", 64'h3333_3333_3333_3333, 8'h02);
        chk("frame_drained", 72'(flags), 72'(7'b1100000));
        // fill to full, then overflow
        for (int i = 1; i <= 256; i++) begin
            wr(64'(i - 1), 8'h00);
            if (i == 239) chk("almost_full_239", 72'(walmost_full), 72'(0));
            if (i == 240) chk("almost_full_240", 72'(walmost_full), 72'(1));
            if (i == 255) chk("full_255", 72'(wfull), 72'(0));
            if (i == 256) chk("full_256", 72'(flags), 72'(7'b0011000));
        end
        wr(64'hBAD0_BAD0_BAD0_BAD0, 8'h02);
        chk("overflow_set", 72'(flags), 72'(7'b0011010));
        chk("overflow_head_intact", {rstatus, rdata}, {8'h00, 64'd0});
        chk("overflow_no_frame", 72'(ravail), 72'(0));
        for (int i = 0; i < 256; i++) begin
            pop_chk("fill_pop", 64'(i), 8'h00);
            if (i == 0) chk("full_clear_after_pop", 72'({wfull, overflow}), 72'(2'b01));
            if (i == 250) chk("almost_empty_occ5", 72'(ralmost_empty), 72'(0));
            if (i == 251) chk("almost_empty_occ4", 72'(ralmost_empty), 72'(1));
        end
        chk("fill_drained", 72'(flags), 72'(7'b1100010));
        // concurrent read/write at occupancy 10, long enough to wrap both pointers
        for (int k = 0; k < 10; k++) wr(64'h1000 + 64'(k), 8'h00);
        wen = 1'b1;
        ren = 1'b1;
        for (int k = 0; k < 260; k++) begin
            wdata = 64'h1000 + 64'(k + 10);
            chk("rw_head", 72'(rdata), 72'(64'h1000 + 64'(k)));
            tick();
        end
        wen = 1'b0;
        ren = 1'b0;
        chk("rw_level", 72'({rempty, ralmost_empty, wfull}), 72'(3'b000));
        for (int k = 260; k < 270; k++) pop_chk("rw_drain", 64'h1000 + 64'(k), 8'h00);
        chk("rw_empty", 72'(rempty), 72'(1));
        // frame count with concurrent EOP write and EOP pop
        wr(64'hA, 8'h03);
        wr(64'hB, 8'h03);
        wdata = 64'hC;
        wstatus = 8'h03;
        wen = 1'b1;
        ren = 1'b1;
        tick();
        wen = 1'b0;
        ren = 1'b0;
        chk("fc_concurrent_ravail", 72'(ravail), 72'(1));
        pop_chk("fc_pop_b", 64'hB, 8'h03);
        chk("fc_one_left", 72'(ravail), 72'(1));
        pop_chk("fc_pop_c", 64'hC, 8'h03);
        chk("fc_zero", 72'({ravail, rempty}), 72'(2'b01));
        // underflow
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("underflow_set", 72'(flags), 72'(7'b1100011));
        wr(64'hDEAD_BEEF_0000_0001, 8'h2A);
        chk("after_underflow_ravail", 72'({rempty, ravail}), 72'(2'b01));
        pop_chk("after_underflow_word", 64'hDEAD_BEEF_0000_0001, 8'h2A);
        chk("after_underflow_empty", 72'(rempty), 72'(1));
        // reset mid-frame discards contents and clears sticky flags
        wr(64'h5, 8'h01);
        wr(64'h6, 8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midframe_reset", 72'(flags), 72'(7'b1100000));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
